mcdf_slave: RTL and testbench



---
 rtl/mcdf_pkg.sv | 10 +
 rtl/slave_fifo.sv | 54 +++++
 rtl/mcdf_slave.sv | 69 ++++++
 tb/tb_mcdf_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcdf_pkg.sv
// rtl/mcdf_pkg.sv - shared constants and word type for the MCDF channel slave
package mcdf_pkg;

   localparam int MCDF_DEPTH = 32;
   localparam int MCDF_DW    = 32;
   localparam int MARGIN_W   = 8;

   typedef logic [MCDF_DW-1:0] word_t;

endpackage

// File: rtl/slave_fifo.sv
// rtl/slave_fifo.sv - synchronous FIFO with occupancy count, storage left unreset
module slave_fifo
   import mcdf_pkg::*;
#(
   parameter int DEPTH = MCDF_DEPTH,
   parameter int DW    = MCDF_DW
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   push,
   input  logic [DW-1:0]          wdata,
   input  logic                   pop,
   output logic [DW-1:0]          rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Guard here too so a careless wrapper can never corrupt the pointers.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push != do_pop)
            count <= do_push ? count + 1'b1 : count - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mcdf_slave.sv
// rtl/mcdf_slave.sv - MCDF channel slave: channel handshake in, FIFO, arbiter req/ack out
// Optional SLAVE_WR_GATE_EN: a disabled slave also stalls its upstream channel.
module mcdf_slave
   import mcdf_pkg::*;
#(
   parameter int DEPTH = MCDF_DEPTH,
   parameter int DW    = MCDF_DW
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [DW-1:0]       chx_data_i,
   input  logic                chx_valid_i,
   output logic                chx_ready_o,
   input  logic                slvx_en_i,
   output logic [MARGIN_W-1:0] margin_o,
   output logic [DW-1:0]       slvx_data_o,
   output logic                slvx_val_o,
   output logic                slvx_req_o,
   input  logic                a2sx_ack_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DW-1:0] head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [CW-1:0] count;

`ifdef SLAVE_WR_GATE_EN
   assign chx_ready_o = ~full & slvx_en_i;
`else
   assign chx_ready_o = ~full;
`endif

   assign push       = chx_valid_i & chx_ready_o;
   assign pop        = slvx_en_i & a2sx_ack_i & ~empty;
   assign slvx_req_o = slvx_en_i & ~empty;
   assign margin_o   = MARGIN_W'(DEPTH - int'(count));

   slave_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .push   (push),
      .wdata  (chx_data_i),
      .pop    (pop),
      .rdata  (head),
      .full   (full),
      .empty  (empty),
      .count  (count)
   );

   // Data holds its last value between pops; val is a one-cycle strobe per word.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         slvx_data_o <= '0;
         slvx_val_o  <= 1'b0;
      end else begin
         slvx_val_o <= pop;
         if (pop)
            slvx_data_o <= head;
      end
   end

endmodule

// File: tb/tb_mcdf_slave.sv
// tb/tb_mcdf_slave.sv - randomized self-checking bench for mcdf_slave against a queue model
module tb_mcdf_slave;
   import mcdf_pkg::*;

   logic                clk_i = 1'b0;
   logic                rstn_i;
   word_t               chx_data_i;
   logic                chx_valid_i;
   logic                chx_ready_o;
   logic                slvx_en_i;
   logic [MARGIN_W-1:0] margin_o;
   word_t               slvx_data_o;
   logic                slvx_val_o;
   logic                slvx_req_o;
   logic                a2sx_ack_i;

   int    n_checks = 0;
   int    n_pass   = 0;
   word_t q[$];
   logic  exp_val;
   word_t exp_data;
   word_t nxt_wr;
   word_t nxt_rd;

   always #5 clk_i = ~clk_i;

   mcdf_slave dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .chx_data_i  (chx_data_i),
      .chx_valid_i (chx_valid_i),
      .chx_ready_o (chx_ready_o),
      .slvx_en_i   (slvx_en_i),
      .margin_o    (margin_o),
      .slvx_data_o (slvx_data_o),
      .slvx_val_o  (slvx_val_o),
      .slvx_req_o  (slvx_req_o),
      .a2sx_ack_i  (a2sx_ack_i)
   );

   function automatic bit model_ready();
      bit r;
      r = q.size() < MCDF_DEPTH;
`ifdef SLAVE_WR_GATE_EN
      r = r && slvx_en_i;
`endif
      return r;
   endfunction

   function automatic logic [MARGIN_W-1:0] model_margin();
      return MARGIN_W'(MCDF_DEPTH - q.size());
   endfunction

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic tick(output bit acc);
      bit    pop;
      word_t d;
      acc = chx_valid_i && model_ready();
      pop = slvx_en_i && a2sx_ack_i && (q.size() > 0);
      d   = chx_data_i;
      @(posedge clk_i);
      exp_val = pop;
      if (pop) exp_data = q.pop_front();
      if (acc) q.push_back(d);
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rstn_i = 1'b0; chx_valid_i = 1'b0; slvx_en_i = 1'b0; a2sx_ack_i = 1'b0; chx_data_i = '0;
      repeat (2) @(negedge clk_i);
      q.delete(); exp_val = 1'b0; exp_data = '0;
      n_checks++; if (chx_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", chx_ready_o); else n_pass++;
      n_checks++; if (margin_o !== 8'd32) $display("FAIL reset_margin: got %0d expected 32", margin_o); else n_pass++;
      n_checks++; if (slvx_req_o !== 1'b0) $display("FAIL reset_req: got %b expected 0", slvx_req_o); else n_pass++;
      n_checks++; if (slvx_val_o !== 1'b0) $display("FAIL reset_val: got %b expected 0", slvx_val_o); else n_pass++;
      n_checks++; if (slvx_data_o !== '0) $display("FAIL reset_data: got %h expected 0", slvx_data_o); else n_pass++;
      rstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_fill();
      bit acc;
      nxt_wr = 32'h00C0_0000; nxt_rd = nxt_wr;
      slvx_en_i = 1'b0; a2sx_ack_i = 1'b0; chx_valid_i = 1'b1;
      for (int i = 0; i < 35; i++) begin
         chx_data_i = nxt_wr;
         tick(acc);
         if (acc) nxt_wr++;
         n_checks++; if (margin_o !== model_margin()) $display("FAIL fill_margin: got %0d expected %0d", margin_o, model_margin()); else n_pass++;
         n_checks++; if (chx_ready_o !== model_ready()) $display("FAIL fill_ready: got %b expected %b", chx_ready_o, model_ready()); else n_pass++;
      end
`ifndef SLAVE_WR_GATE_EN
      n_checks++; if (margin_o !== 8'd0) $display("FAIL full_margin: got %0d expected 0", margin_o); else n_pass++;
      n_checks++; if (chx_ready_o !== 1'b0) $display("FAIL full_ready: got %b expected 0", chx_ready_o); else n_pass++;
`endif
      n_checks++; if (slvx_req_o !== 1'b0) $display("FAIL full_req: got %b expected 0", slvx_req_o); else n_pass++;
   endtask

   task automatic test_drain();
      bit acc;
      slvx_en_i = 1'b1; a2sx_ack_i = 1'b1; chx_valid_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         chx_data_i = nxt_wr;
         tick(acc);
         if (acc) nxt_wr++;
         n_checks++; if (slvx_val_o !== exp_val) $display("FAIL drain_val: got %b expected %b", slvx_val_o, exp_val); else n_pass++;
         n_checks++; if (slvx_data_o !== exp_data) $display("FAIL drain_data: got %h expected %h", slvx_data_o, exp_data); else n_pass++;
         if (exp_val) begin
            n_checks++; if (slvx_data_o !== nxt_rd) $display("FAIL drain_order: got %h expected %h", slvx_data_o, nxt_rd); else n_pass++;
            nxt_rd++;
         end
         n_checks++; if (margin_o !== model_margin()) $display("FAIL drain_margin: got %0d expected %0d", margin_o, model_margin()); else n_pass++;
      end
   endtask

   task automatic test_disable();
      bit acc;
      slvx_en_i = 1'b0; a2sx_ack_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chx_valid_i = 1'($urandom_range(0, 1));
         chx_data_i  = nxt_wr;
         tick(acc);
         if (acc) nxt_wr++;
         n_checks++; if (slvx_req_o !== 1'b0) $display("FAIL dis_req: got %b expected 0", slvx_req_o); else n_pass++;
         n_checks++; if (slvx_val_o !== 1'b0) $display("FAIL dis_val: got %b expected 0", slvx_val_o); else n_pass++;
         n_checks++; if (margin_o !== model_margin()) $display("FAIL dis_margin: got %0d expected %0d", margin_o, model_margin()); else n_pass++;
      end
      slvx_en_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chx_valid_i = 1'($urandom_range(0, 1));
         chx_data_i  = nxt_wr;
         tick(acc);
         if (acc) nxt_wr++;
         n_checks++; if (slvx_val_o !== exp_val) $display("FAIL reen_val: got %b expected %b", slvx_val_o, exp_val); else n_pass++;
         if (exp_val) begin
            n_checks++; if (slvx_data_o !== nxt_rd) $display("FAIL reen_order: got %h expected %h", slvx_data_o, nxt_rd); else n_pass++;
            nxt_rd++;
         end
      end
   endtask

   task automatic test_stream();
      bit acc;
      int n_seen;
      chx_valid_i = 1'b0; slvx_en_i = 1'b1; a2sx_ack_i = 1'b1;
      for (int i = 0; i < 40 && q.size() > 0; i++) tick(acc);
      n_checks++; if (slvx_req_o !== 1'b0) $display("FAIL stream_empty_req: got %b expected 0", slvx_req_o); else n_pass++;
      nxt_wr = 32'h00C0_0000; nxt_rd = nxt_wr; n_seen = 0;
      for (int i = 0; i < 100 && n_seen < 64; i++) begin
         chx_valid_i = (nxt_wr < 32'h00C0_0040);
         chx_data_i  = nxt_wr;
         tick(acc);
         if (acc) nxt_wr++;
         if (slvx_val_o === 1'b1) n_seen++;
         if (acc) begin
            n_checks++; if (margin_o !== 8'd31) $display("FAIL stream_margin: got %0d expected 31", margin_o); else n_pass++;
         end
         if (exp_val) begin
            n_checks++; if (slvx_data_o !== nxt_rd || slvx_val_o !== 1'b1) $display("FAIL stream_data: got %h/%b expected %h/1", slvx_data_o, slvx_val_o, nxt_rd); else n_pass++;
            nxt_rd++;
         end
      end
      n_checks++; if (n_seen != 64) $display("FAIL stream_count: got %0d expected 64", n_seen); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit    acc;
      word_t w;
      slvx_en_i = 1'b0; a2sx_ack_i = 1'b0; chx_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chx_data_i = word_t'($urandom);
         tick(acc);
      end
      chx_valid_i = 1'b0; slvx_en_i = 1'b1; a2sx_ack_i = 1'b1;
      tick(acc);
      n_checks++; if (slvx_val_o !== 1'b1) $display("FAIL pre_rst_val: got %b expected 1", slvx_val_o); else n_pass++;
      #2 rstn_i = 1'b0;
      #1;
      q.delete(); exp_val = 1'b0; exp_data = '0;
      n_checks++; if (margin_o !== 8'd32) $display("FAIL mid_rst_margin: got %0d expected 32", margin_o); else n_pass++;
      n_checks++; if (slvx_req_o !== 1'b0) $display("FAIL mid_rst_req: got %b expected 0", slvx_req_o); else n_pass++;
      n_checks++; if (slvx_val_o !== 1'b0) $display("FAIL mid_rst_val: got %b expected 0", slvx_val_o); else n_pass++;
      @(negedge clk_i);
      rstn_i = 1'b1;
      w = word_t'($urandom);
      chx_data_i = w; chx_valid_i = 1'b1; a2sx_ack_i = 1'b0;
      n_checks++; if (slvx_req_o !== 1'b0) $display("FAIL post_rst_req0: got %b expected 0", slvx_req_o); else n_pass++;
      tick(acc);
      n_checks++; if (slvx_req_o !== 1'b1) $display("FAIL post_rst_req1: got %b expected 1", slvx_req_o); else n_pass++;
      chx_valid_i = 1'b0; a2sx_ack_i = 1'b1;
      tick(acc);
      n_checks++; if (slvx_val_o !== 1'b1 || slvx_data_o !== w) $display("FAIL post_rst_word: got %h/%b expected %h/1", slvx_data_o, slvx_val_o, w); else n_pass++;
   endtask

   task automatic test_random();
      bit acc;
      for (int i = 0; i < 300; i++) begin
         chx_valid_i = 1'($urandom_range(0, 3) != 0);
         slvx_en_i   = 1'($urandom_range(0, 7) != 0);
         a2sx_ack_i  = 1'($urandom_range(0, 2) == 0);
         chx_data_i  = word_t'($urandom);
         tick(acc);
         n_checks++; if (slvx_val_o !== exp_val) $display("FAIL rnd_val: got %b expected %b", slvx_val_o, exp_val); else n_pass++;
         n_checks++; if (slvx_data_o !== exp_data) $display("FAIL rnd_data: got %h expected %h", slvx_data_o, exp_data); else n_pass++;
         n_checks++; if (margin_o !== model_margin()) $display("FAIL rnd_margin: got %0d expected %0d", margin_o, model_margin()); else n_pass++;
         n_checks++; if (slvx_req_o !== (slvx_en_i && q.size() > 0)) $display("FAIL rnd_req: got %b expected %b", slvx_req_o, (slvx_en_i && q.size() > 0)); else n_pass++;
         n_checks++; if (chx_ready_o !== model_ready()) $display("FAIL rnd_ready: got %b expected %b", chx_ready_o, model_ready()); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_disable();
      test_stream();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
